ysyx_23060061_mdu: RTL and testbench

YSYX_23060061_MDU -- requirements
Module: ysyx_23060061_MDU

---
 rtl/ysyx_23060061_mdu_if.sv | 17 +
 rtl/ysyx_23060061_mdu.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_23060061_mdu.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060061_mdu_if.sv
// Request/response bundle between the pipeline and the RV32M multiply/divide unit.
interface ysyx_23060061_mdu_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       mduOp;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] mduOut;

  modport master (output in_valid, a, b, mduOp, flush, out_ready,
                  input  in_ready, out_valid, mduOut);
  modport slave  (input  in_valid, a, b, mduOp, flush, out_ready,
                  output in_ready, out_valid, mduOut);
endinterface

// File: rtl/ysyx_23060061_mdu.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// 32 iteration cycles, divide-by-zero and signed overflow answered at once.
// Only WIDTH = 32 is supported.
module ysyx_23060061_mdu #(parameter int WIDTH = 32) (
  input  logic clk,
  input  logic rst,
  ysyx_23060061_mdu_if.slave io
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [63:0]      prod_q, prod_d, mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d, quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic             negq_q, negq_d, negr_q, negr_d, bneg_q, bneg_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.mduOut    = res_q;

  // Request decode: operand signedness, magnitudes and the two early-out cases.
  logic        is_div, div_sgn, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [31:0] a_mag, b_mag;
  assign is_div   = io.mduOp[2];
  assign div_sgn  = is_div & ~io.mduOp[0];
  assign a_sgn    = is_div ? div_sgn : (io.mduOp[1:0] == 2'b01 || io.mduOp[1:0] == 2'b10);
  assign b_sgn    = is_div ? div_sgn : (io.mduOp[1:0] == 2'b01);
  assign a_neg    = a_sgn & io.a[31];
  assign b_neg    = b_sgn & io.b[31];
  assign a_mag    = a_neg ? 32'd0 - io.a : io.a;
  assign b_mag    = b_neg ? 32'd0 - io.b : io.b;
  assign div_zero = is_div & (io.b == 32'd0);
  assign div_ovf  = div_sgn & (io.a == 32'h8000_0000) & (io.b == 32'hFFFF_FFFF);

  // One iteration of both datapaths plus the sign/select fix-up applied on the last one.
  // The multiplier is consumed as unsigned bits; a negative signed multiplier is
  // corrected at the end by subtracting a<<32, which is exactly mcand after 32 shifts.
  logic [63:0]      prod_s, mcand_s, prod_fix;
  logic [31:0]      mplier_s, quo_s, rem_s, q_fix, r_fix;
  logic [32:0]      rsh, diff;
  logic [WIDTH-1:0] fin;
  always_comb begin
    prod_s   = mplier_q[0] ? prod_q + mcand_q : prod_q;
    mcand_s  = mcand_q << 1;
    mplier_s = mplier_q >> 1;
    rsh      = {rem_q, quo_q[31]};
    diff     = rsh - {1'b0, dvsr_q};
    if (diff[32]) begin
      rem_s = rsh[31:0];
      quo_s = {quo_q[30:0], 1'b0};
    end else begin
      rem_s = diff[31:0];
      quo_s = {quo_q[30:0], 1'b1};
    end
    prod_fix = prod_s - (bneg_q ? mcand_s : 64'd0);
    q_fix    = negq_q ? 32'd0 - quo_s : quo_s;
    r_fix    = negr_q ? 32'd0 - rem_s : rem_s;
    case (op_q)
      3'b000:                 fin = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: fin = prod_fix[63:32];
      3'b100, 3'b101:         fin = q_fix;
      default:                fin = r_fix;
    endcase
  end

  // Next-state logic for the IDLE/BUSY/DONE sequencer and all datapath registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvsr_d      = dvsr_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    bneg_d      = bneg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    unique case (state_q)
      IDLE: if (io.in_valid) begin
        op_d       = io.mduOp;
        cnt_d      = 6'd0;
        prod_d     = 64'd0;
        mcand_d    = a_sgn ? {{32{io.a[31]}}, io.a} : {32'd0, io.a};
        mplier_d   = io.b;
        bneg_d     = b_neg;
        quo_d      = a_mag;
        rem_d      = 32'd0;
        dvsr_d     = b_mag;
        negq_d     = a_neg ^ b_neg;
        negr_d     = a_neg;
        in_ready_d = 1'b0;
        if (div_zero) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          res_d       = io.mduOp[1] ? io.a : '1;
        end else if (div_ovf) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          res_d       = io.mduOp[1] ? '0 : 32'h8000_0000;
        end else begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        prod_d   = prod_s;
        mcand_d  = mcand_s;
        mplier_d = mplier_s;
        quo_d    = quo_s;
        rem_d    = rem_s;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          res_d       = fin;
        end
      end
      DONE: if (io.out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        res_d       = '0;
        in_ready_d  = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        res_d       = '0;
        in_ready_d  = 1'b1;
      end
    endcase
    // Flush wins over everything else and throws the result away.
    if (io.flush) begin
      state_d     = IDLE;
      cnt_d       = 6'd0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      res_d       = '0;
    end
  end

  // State register; reset leaves the unit idle and ready with all datapath state cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      op_q        <= 3'd0;
      prod_q      <= 64'd0;
      mcand_q     <= 64'd0;
      mplier_q    <= 32'd0;
      quo_q       <= 32'd0;
      rem_q       <= 32'd0;
      dvsr_q      <= 32'd0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      bneg_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvsr_q      <= dvsr_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      bneg_q      <= bneg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end
endmodule

// File: tb/tb_ysyx_23060061_mdu.sv
// Scoreboard bench: the driver pushes expected result and latency per request,
// a monitor pops and compares whenever a result is handed over.
module tb_ysyx_23060061_mdu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060061_mdu_if #(.WIDTH(32)) io();
  ysyx_23060061_mdu #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .io(io));

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   hold  = 0;   // 0: random out_ready, 1: forced low, 2: forced high
  bit   prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            else return 32'(ia / ib);
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return 32'(ia % ib);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit track, input logic [31:0] exp, input int lat);
    int n = 0;
    while (!io.in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("ready_timeout", {31'd0, io.in_ready}, 32'd1);
    io.in_valid = 1'b1;
    io.a        = a;
    io.b        = b;
    io.mduOp    = op;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.a        = $urandom;
    io.b        = $urandom;
    io.mduOp    = 3'($urandom_range(0, 7));
    if (track) q.push_back('{data: exp, lat: lat, acc: cyc});
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain", q.size(), 32'd0);
    q.delete();
  endtask

  // Monitor: drives out_ready, checks latency on the rising out_valid and data on handover.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov      = 1'b0;
        io.out_ready = 1'b0;
      end else begin
        case (hold)
          0:       io.out_ready = ($urandom_range(0, 3) != 0);
          1:       io.out_ready = 1'b0;
          default: io.out_ready = 1'b1;
        endcase
        if (!io.out_valid) chk("out_zero_when_invalid", io.mduOut, 32'd0);
        if (io.out_valid && !prev_ov) begin
          if (q.size() == 0) chk("unexpected_valid", {31'd0, io.out_valid}, 32'd0);
          else chk("latency", cyc - q[0].acc, q[0].lat);
        end
        if (io.out_valid && io.out_ready && q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("result", io.mduOut, e.data);
        end
        prev_ov = io.out_valid;
      end
    end
  end

  logic [2:0]  d_op [10] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'd7, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                             32'hFFFFFFFE, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_r  [10] = '{32'h00000001, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'd7, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
  int          d_l  [10] = '{32, 32, 32, 32, 32, 32, 0, 0, 0, 0};

  initial begin
    rst         = 1'b1;
    io.in_valid = 1'b0;
    io.flush    = 1'b0;
    io.a        = '0;
    io.b        = '0;
    io.mduOp    = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", {31'd0, io.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("reset_mduOut", io.mduOut, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases with hand-derived results.
    for (int i = 0; i < 10; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1, d_r[i], d_l[i]);
    drain();

    // Result must sit still while the consumer stalls.
    hold = 1;
    issue(3'd0, 32'd3, 32'd5, 1'b1, 32'd15, 32);
    begin
      int n = 0;
      while (!io.out_valid && n < 60) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_out_valid", {31'd0, io.out_valid}, 32'd1);
      chk("hold_mduOut", io.mduOut, 32'd15);
      chk("hold_in_ready", {31'd0, io.in_ready}, 32'd0);
      @(negedge clk);
    end
    hold = 2;
    repeat (2) @(negedge clk);
    chk("release_in_ready", {31'd0, io.in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, io.out_valid}, 32'd0);
    hold = 0;
    drain();

    // Flush mid-operation, then a clean MULHSU.
    issue(3'd4, 32'd1000, 32'd7, 1'b0, 32'd0, 0);
    repeat (9) @(negedge clk);
    io.flush = 1'b1;
    @(posedge clk);
    #1;
    io.flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, io.in_ready}, 32'd1);
    chk("flush_out_valid", {31'd0, io.out_valid}, 32'd0);
    issue(3'd2, 32'hFFFFFFFF, 32'd2, 1'b1, 32'hFFFFFFFF, 32);
    drain();

    // Asynchronous reset mid-operation, then a power-up style request.
    issue(3'd1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'd0, 0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_in_ready", {31'd0, io.in_ready}, 32'd1);
    chk("async_rst_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("async_rst_mduOut", io.mduOut, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd1, 32);
    drain();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          sel;
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 16));
      else if (sel == 3) a = 32'($urandom_range(0, 40));
      issue(op, a, b, 1'b1, ref_model(op, a, b), ref_lat(op, a, b));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
